// File: rtl/button_pkg.sv
// Shared types and constants for the button_pulse block.
// FSM state encoding, synchronizer depth and a small elaboration helper.
// The BUTTON_PULSE_REPEAT_EN macro selects the auto-repeat FSM in
// button_pulse; this package is identical in both builds.
package button_pkg;

    // IDLE/DELAY/REPEAT are used with auto-repeat enabled, IDLE/HELD without it.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2,
        HELD   = 2'd3
    } button_state_e;

    // Number of flops between the raw pin and the debounce logic.
    localparam int sync_stages_lp = 2;

    // Larger of two integers, used to size the repeat timer at elaboration.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_pulse_if.sv
// Signal bundle between one pushbutton conditioner and its consumer.
// btn_i is the raw pin level; level_o and pulse_o are registered results;
// state_o exposes the press FSM for observation. There is no handshake:
// pulse_o is a one-cycle strobe that the consumer must sample every cycle,
// and level_o is a steady level that may be sampled at any time.
interface button_pulse_if;
    import button_pkg::*;

    logic          btn_i;
    logic          level_o;
    logic          pulse_o;
    button_state_e state_o;

    // Consumer side: drives the button, observes the results.
    modport master (
        output btn_i,
        input  level_o,
        input  pulse_o,
        input  state_o
    );

    // Conditioner side.
    modport slave (
        input  btn_i,
        output level_o,
        output pulse_o,
        output state_o
    );

endinterface

// File: rtl/button_sync.sv
// Multi-flop synchronizer for one asynchronous input bit.
// Depth comes from button_pkg::sync_stages_lp; all stages reset to 0.
module button_sync
    import button_pkg::*;
(
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic d_i,
    output logic q_o
);

    logic [sync_stages_lp-1:0] stages_r;

    // Shift the raw level through the stages; stage 0 may go metastable.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stages_r <= '0;
        end else begin
            stages_r <= {stages_r[sync_stages_lp-2:0], d_i};
        end
    end

    assign q_o = stages_r[sync_stages_lp-1];

endmodule

// File: rtl/button_pulse.sv
// Pushbutton conditioner: synchronizer -> debounce counter -> press FSM ->
// registered single-cycle pulse. One instance per button.
// Build option: define BUTTON_PULSE_REPEAT_EN for press-and-hold
// auto-repeat (IDLE/DELAY/REPEAT with a repeat timer). Without it the FSM
// is IDLE/HELD, one pulse per press, and the repeat_* parameters are unused.
module button_pulse
    import button_pkg::*;
#(
    parameter int debounce_cycles_p = 1000000,
    parameter int repeat_delay_p    = 50000000,
    parameter int repeat_period_p   = 10000000
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    button_pulse_if.slave bus
);

    // Reject nonsensical configurations at elaboration.
    if (debounce_cycles_p < 1 || repeat_delay_p < 1 || repeat_period_p < 1) begin : g_bad_params
        $error("button_pulse: all cycle-count parameters must be >= 1");
    end

    // ------------------------------------------------------------------
    // Synchronizer
    // ------------------------------------------------------------------
    logic sync_r;

    button_sync u_sync (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .d_i       (bus.btn_i),
        .q_o       (sync_r)
    );

    // ------------------------------------------------------------------
    // Debounce
    // ------------------------------------------------------------------
    localparam int deb_w_lp = $clog2(debounce_cycles_p + 1);
    localparam logic [deb_w_lp-1:0] deb_last_lp = deb_w_lp'(debounce_cycles_p - 1);

    logic [deb_w_lp-1:0] deb_cnt_r;
    logic                level_r;
    logic                level_d;
    logic                level_differs;
    logic                deb_done;
    logic                level_rise;

    assign level_differs = (sync_r != level_r);
    assign deb_done      = level_differs && (deb_cnt_r == deb_last_lp);

    // Value level_r takes on the coming edge; the FSM reacts to it so the
    // first pulse leaves on the same edge as the debounced level.
    always_comb begin
        level_d = level_r;
        if (deb_done) begin
            level_d = ~level_r;
        end
    end

    assign level_rise = level_d && !level_r;

    // Count consecutive disagreeing cycles; any agreeing cycle restarts.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            deb_cnt_r <= '0;
            level_r   <= 1'b0;
        end else if (!level_differs) begin
            deb_cnt_r <= '0;
        end else if (deb_done) begin
            deb_cnt_r <= '0;
            level_r   <= ~level_r;
        end else begin
            deb_cnt_r <= deb_cnt_r + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Press FSM
    // ------------------------------------------------------------------
    button_state_e state_r;
    button_state_e state_d;
    logic          pulse_r;
    logic          pulse_d;

`ifdef BUTTON_PULSE_REPEAT_EN
    localparam int timer_span_lp = max_int(repeat_delay_p, repeat_period_p);
    localparam int timer_w_lp    = (timer_span_lp > 1) ? $clog2(timer_span_lp) : 1;
    localparam logic [timer_w_lp-1:0] delay_load_lp  = timer_w_lp'(repeat_delay_p - 1);
    localparam logic [timer_w_lp-1:0] period_load_lp = timer_w_lp'(repeat_period_p - 1);

    logic [timer_w_lp-1:0] timer_r;
    logic [timer_w_lp-1:0] timer_d;
    logic                  timer_zero;

    assign timer_zero = (timer_r == '0);
`endif

    // State, timer and pulse registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
            pulse_r <= 1'b0;
`ifdef BUTTON_PULSE_REPEAT_EN
            timer_r <= '0;
`endif
        end else begin
            state_r <= state_d;
            pulse_r <= pulse_d;
`ifdef BUTTON_PULSE_REPEAT_EN
            timer_r <= timer_d;
`endif
        end
    end

    // Next state: a debounced release always returns to IDLE, and it takes
    // priority over a timer expiry on the same cycle.
    always_comb begin
        state_d = state_r;
        case (state_r)
`ifdef BUTTON_PULSE_REPEAT_EN
            IDLE: begin
                if (level_rise) begin
                    state_d = DELAY;
                end
            end
            DELAY: begin
                if (!level_d) begin
                    state_d = IDLE;
                end else if (timer_zero) begin
                    state_d = REPEAT;
                end
            end
            REPEAT: begin
                if (!level_d) begin
                    state_d = IDLE;
                end
            end
`else
            IDLE: begin
                if (level_rise) begin
                    state_d = HELD;
                end
            end
            HELD: begin
                if (!level_d) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Outputs: pulse request and timer update. The timer counts down to 0
    // and is reloaded there, so it never wraps.
    always_comb begin
        pulse_d = 1'b0;
`ifdef BUTTON_PULSE_REPEAT_EN
        timer_d = timer_r;
`endif
        case (state_r)
`ifdef BUTTON_PULSE_REPEAT_EN
            IDLE: begin
                if (level_rise) begin
                    pulse_d = 1'b1;
                    timer_d = delay_load_lp;
                end
            end
            DELAY, REPEAT: begin
                if (level_d) begin
                    if (timer_zero) begin
                        pulse_d = 1'b1;
                        timer_d = period_load_lp;
                    end else begin
                        timer_d = timer_r - 1'b1;
                    end
                end
            end
`else
            IDLE: begin
                if (level_rise) begin
                    pulse_d = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    assign bus.level_o = level_r;
    assign bus.pulse_o = pulse_r;
    assign bus.state_o = state_r;

endmodule

// File: tb/tb_button_pulse.sv
// Directed bench for button_pulse with debounce 4, repeat delay 8,
// repeat period 3. Expectations follow the build: with
// BUTTON_PULSE_REPEAT_EN defined, held presses add auto-repeat pulses.
module tb_button_pulse;
    import button_pkg::*;

    localparam int deb_lp    = 4;
    localparam int delay_lp  = 8;
    localparam int period_lp = 3;
    localparam int window_lp = 60;

`ifdef BUTTON_PULSE_REPEAT_EN
    localparam bit rep_en = 1'b1;
`else
    localparam bit rep_en = 1'b0;
`endif

    logic clk;
    logic reset_n;
    int   n_vec;
    int   n_err;

    button_pulse_if bus_if ();

    button_pulse #(
        .debounce_cycles_p (deb_lp),
        .repeat_delay_p    (delay_lp),
        .repeat_period_p   (period_lp)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .bus       (bus_if.slave)
    );

    // ------------------------------------------------------------------
    // Clock
    // ------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic check(input string name, input int edge_n,
                         input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, act, exp);
        end
    endtask

    // One press: btn_i high from edge 0 for 'hold' edges. Level expected
    // high for edges lvl_lo..lvl_hi (lvl_lo < 0: never). Pulses at lvl_lo and,
    // with auto-repeat, at rep_first + k*period up to rep_last (0: none).
    typedef struct {
        int hold;
        int lvl_lo;
        int lvl_hi;
        int rep_first;
        int rep_last;
    } vec_t;

    vec_t vecs[8];

    logic [1:0] exp_q[$];

    // Expand one table row into per-edge {level, pulse} expectations.
    task automatic build_expect(input vec_t v);
        logic el;
        logic ep;
        exp_q.delete();
        for (int e = 0; e < window_lp; e++) begin
            el = (v.lvl_lo >= 0) && (e >= v.lvl_lo) && (e <= v.lvl_hi);
            ep = (v.lvl_lo >= 0) && (e == v.lvl_lo);
            if (rep_en && v.rep_first > 0 && e >= v.rep_first && e <= v.rep_last &&
                ((e - v.rep_first) % period_lp) == 0) begin
                ep = 1'b1;
            end
            exp_q.push_back({el, ep});
        end
    endtask

    // Driver: apply one press and compare every edge against the queue.
    task automatic run_vec(input vec_t v, input int id);
        logic [1:0] exp;
        string      tag;
        build_expect(v);
        tag = $sformatf("vec%0d", id);
        @(negedge clk);
        bus_if.btn_i = (v.hold > 0);
        for (int e = 0; e < window_lp; e++) begin
            @(posedge clk);
            #1;
            exp = exp_q.pop_front();
            check({tag, " level"}, e, 32'(bus_if.level_o), 32'(exp[1]));
            check({tag, " pulse"}, e, 32'(bus_if.pulse_o), 32'(exp[0]));
            bus_if.btn_i = (e + 1 < v.hold);
        end
        check({tag, " end state"}, window_lp, 32'(bus_if.state_o), 32'(IDLE));
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        n_vec = 0;
        n_err = 0;

        vecs[0] = '{hold: 3,  lvl_lo: -1, lvl_hi: -1, rep_first: 0,  rep_last: 0};
        vecs[1] = '{hold: 4,  lvl_lo: 5,  lvl_hi: 8,  rep_first: 0,  rep_last: 0};
        vecs[2] = '{hold: 6,  lvl_lo: 5,  lvl_hi: 10, rep_first: 0,  rep_last: 0};
        vecs[3] = '{hold: 8,  lvl_lo: 5,  lvl_hi: 12, rep_first: 0,  rep_last: 0};
        vecs[4] = '{hold: 9,  lvl_lo: 5,  lvl_hi: 13, rep_first: 13, rep_last: 13};
        vecs[5] = '{hold: 11, lvl_lo: 5,  lvl_hi: 15, rep_first: 13, rep_last: 13};
        vecs[6] = '{hold: 13, lvl_lo: 5,  lvl_hi: 17, rep_first: 13, rep_last: 16};
        vecs[7] = '{hold: 40, lvl_lo: 5,  lvl_hi: 44, rep_first: 13, rep_last: 43};

        // Reset held with the button pressed: outputs stay clear.
        reset_n      = 1'b0;
        bus_if.btn_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset level", 0, 32'(bus_if.level_o), 32'd0);
        check("reset pulse", 0, 32'(bus_if.pulse_o), 32'd0);
        check("reset state", 0, 32'(bus_if.state_o), 32'(IDLE));

        // Release reset with button held: press seen at edge 1, pulse at 6.
        @(negedge clk);
        reset_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            #1;
            check("post-reset level", e, 32'(bus_if.level_o), 32'(e >= 6));
            check("post-reset pulse", e, 32'(bus_if.pulse_o), 32'(e == 6));
        end

        // Asynchronous reset mid-press clears outputs without a clock edge.
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset level", 0, 32'(bus_if.level_o), 32'd0);
        check("async reset state", 0, 32'(bus_if.state_o), 32'(IDLE));

        // Still held after reset: a fresh press with full latency.
        @(negedge clk);
        reset_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            #1;
            check("re-press level", e, 32'(bus_if.level_o), 32'(e >= 6));
            check("re-press pulse", e, 32'(bus_if.pulse_o), 32'(e == 6));
        end
        bus_if.btn_i = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("idle after release", 0, 32'(bus_if.level_o), 32'd0);

        // Bounce: toggle every 2 cycles for 24 cycles, never long enough.
        @(negedge clk);
        bus_if.btn_i = 1'b1;
        for (int e = 0; e < 34; e++) begin
            @(posedge clk);
            #1;
            check("bounce level", e, 32'(bus_if.level_o), 32'd0);
            check("bounce pulse", e, 32'(bus_if.pulse_o), 32'd0);
            bus_if.btn_i = (e + 1 < 24) ? (((e + 1) / 2) % 2 == 0) : 1'b0;
        end
        repeat (8) @(posedge clk);

        // Table of single presses.
        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
            bus_if.btn_i = 1'b0;
            repeat (8) @(posedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
